// File: rtl/cam_pixel_packer.sv
// Packs camera bytes into little-endian 64-bit words framed by vsync, buffered in an output FIFO.
// Define CAM_PACK_DROP_CNT_EN to build the dropped-word counter behind drop_cnt.
module cam_pixel_packer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pixel_valid,
    input  logic [7:0]  pixel,
    input  logic        vsync,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        overflow,
    output logic [31:0] word_cnt,
    output logic [15:0] drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH_PART} state_e;

    state_e        state_q;
    logic          vsync_p1_q;
    logic [2:0]    idx_q;
    logic [63:0]   part_q;
    logic [63:0]   hold_q;
    logic          hold_vld_q;
    logic [31:0]   frame_cnt_q;
    logic          overflow_q;
    logic [31:0]   word_cnt_q;

    logic [63:0]   fifo_data_q [FIFO_DEPTH];
    logic          fifo_last_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic          vs_rise;
    logic          frame_start;
    logic [63:0]   part_d;
    logic          push_req;
    logic          push_last;
    logic [63:0]   push_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [31:0]   frame_cnt_d;

    always_comb begin
        vs_rise     = vsync && !vsync_p1_q;
        frame_start = (state_q == IDLE) && vs_rise && enable;

        part_d = part_q;
        part_d[{idx_q, 3'b000} +: 8] = pixel;

        // A completed word first displaces the held one; the frame end flushes hold, then partial.
        push_req  = 1'b0;
        push_last = 1'b0;
        push_data = hold_q;
        case (state_q)
            RUN: begin
                if (vs_rise) begin
                    push_req  = hold_vld_q;
                    push_last = (idx_q == 3'd0);
                end else if (pixel_valid && idx_q == 3'd7) begin
                    push_req  = hold_vld_q;
                end
            end
            FLUSH_PART: begin
                push_req  = 1'b1;
                push_last = 1'b1;
                push_data = part_q;
            end
            default: ;
        endcase

        fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && out_ready;
        push_ok    = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;

        frame_cnt_d = (push_ok && frame_cnt_q != '1) ? frame_cnt_q + 32'd1 : frame_cnt_q;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vsync_p1_q  <= 1'b0;
            idx_q       <= '0;
            part_q      <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            vsync_p1_q <= vsync;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q     <= RUN;
                        overflow_q  <= 1'b0;
                        idx_q       <= '0;
                        part_q      <= '0;
                        hold_vld_q  <= 1'b0;
                        frame_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (vs_rise) begin
                        hold_vld_q <= 1'b0;
                        if (idx_q == 3'd0) begin
                            word_cnt_q  <= frame_cnt_d;
                            frame_cnt_q <= '0;
                            state_q     <= enable ? RUN : IDLE;
                        end else begin
                            frame_cnt_q <= frame_cnt_d;
                            state_q     <= FLUSH_PART;
                        end
                    end else if (pixel_valid) begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            hold_q      <= part_d;
                            hold_vld_q  <= 1'b1;
                            part_q      <= '0;
                            frame_cnt_q <= frame_cnt_d;
                        end else begin
                            part_q <= part_d;
                        end
                    end
                end
                FLUSH_PART: begin
                    word_cnt_q  <= frame_cnt_d;
                    frame_cnt_q <= '0;
                    idx_q       <= '0;
                    part_q      <= '0;
                    state_q     <= enable ? RUN : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the head is masked to zero while empty instead.
    always_ff @(posedge pclk) begin
        if (push_ok) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_last_q[wr_ptr_q] <= push_last;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
    assign out_last  = fifo_empty ? 1'b0 : fifo_last_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign word_cnt  = word_cnt_q;

`ifdef CAM_PACK_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (frame_start) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Self-checking bench for cam_pixel_packer: directed frame scenarios plus random frames
// compared against a byte-list packing model through a word scoreboard.
module tb_cam_pixel_packer;

    localparam int DEPTH = 4;
`ifdef CAM_PACK_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [7:0]  pixel = 8'h00;
    logic        vsync = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_last;
    logic        overflow;
    logic [31:0] word_cnt;
    logic [15:0] drop_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_ready = 1'b0;
    exp_t sb_q[$];
    logic [7:0] frame_q[$];

    cam_pixel_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .pclk        (pclk),
        .rst         (rst),
        .enable      (enable),
        .pixel_valid (pixel_valid),
        .pixel       (pixel),
        .vsync       (vsync),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .overflow    (overflow),
        .word_cnt    (word_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every accepted transfer must match the next expected word.
    always @(negedge pclk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            assert (sb_q.size() != 0) else begin
                n_err++;
                $error("FAIL spurious_word observed=%h expected=none", out_data);
            end
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", 64'(out_last), 64'(e.last));
            end
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
    endtask

    task automatic vs_pulse(input logic en);
        enable = en;
        vsync  = 1'b1;
        step();
        step();
        vsync = 1'b0;
        step();
        step();
    endtask

    task automatic make_frame(input int n, input int base, input bit rnd);
        frame_q.delete();
        for (int i = 0; i < n; i++)
            frame_q.push_back(rnd ? 8'($urandom_range(255)) : 8'(base + i));
    endtask

    task automatic send_frame(input int gap_pct);
        foreach (frame_q[i]) begin
            while ($urandom_range(99) < gap_pct) begin
                pixel_valid = 1'b0;
                step();
            end
            pixel_valid = 1'b1;
            pixel       = frame_q[i];
            step();
        end
        pixel_valid = 1'b0;
    endtask

    // Reference: bytes fill words little-endian, final word zero-padded and marked last.
    task automatic expect_frame(input int limit);
        int n  = frame_q.size();
        int nw = (n + 7) / 8;
        for (int w = 0; w < nw && w < limit; w++) begin
            exp_t e;
            e.data = '0;
            for (int j = 0; j < 8; j++)
                if (8 * w + j < n) e.data = e.data | (64'(frame_q[8 * w + j]) << (8 * j));
            e.last = (w == nw - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while (sb_q.size() != 0 && cyc < 300) begin
            step();
            cyc++;
        end
        check(tag, 64'(sb_q.size()), 64'd0);
        @(negedge pclk);
        check({tag, "_empty"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        exp_t e;
        int   n;

        // Reset state
        @(negedge pclk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        step();
        rst = 1'b0;
        step();

        // 16 sequential bytes -> two full words
        out_ready = 1'b1;
        vs_pulse(1'b1);
        e.data = 64'h0706050403020100; e.last = 1'b0; sb_q.push_back(e);
        e.data = 64'h0F0E0D0C0B0A0908; e.last = 1'b1; sb_q.push_back(e);
        make_frame(16, 8'h00, 1'b0);
        send_frame(0);
        vs_pulse(1'b1);
        drain("f16_drain");
        check("f16_word_cnt", 64'(word_cnt), 64'd2);
        check("f16_overflow", 64'(overflow), 64'd0);

        // 10 bytes -> one full word plus zero-padded partial
        e.data = 64'h1716151413121110; e.last = 1'b0; sb_q.push_back(e);
        e.data = 64'h0000000000001918; e.last = 1'b1; sb_q.push_back(e);
        make_frame(10, 8'h10, 1'b0);
        send_frame(0);
        vs_pulse(1'b1);
        drain("f10_drain");
        check("f10_word_cnt", 64'(word_cnt), 64'd2);

        // Backpressure overflow, then reset mid-frame
        out_ready = 1'b0;
        make_frame(48, 8'h40, 1'b0);
        send_frame(0);
        @(negedge pclk);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drop_pre", 64'(drop_cnt), DROP_EN ? 64'd1 : 64'd0);
        vs_pulse(1'b1);
        check("ovf_word_cnt", 64'(word_cnt), 64'd4);
        check("ovf_drop_post", 64'(drop_cnt), DROP_EN ? 64'd2 : 64'd0);
        make_frame(5, 8'hA0, 1'b0);
        send_frame(0);
        @(negedge pclk);
        check("ovf_head_valid", 64'(out_valid), 64'd1);
        check("ovf_head_data", out_data, 64'h4746454443424140);
        check("ovf_head_last", 64'(out_last), 64'd0);
        step();
        rst = 1'b1;
        @(negedge pclk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_out_last", 64'(out_last), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        check("mid_rst_word_cnt", 64'(word_cnt), 64'd0);
        check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // Disabled frame: bytes ignored, nothing emitted
        vs_pulse(1'b0);
        make_frame(8, 8'h55, 1'b0);
        send_frame(0);
        vs_pulse(1'b0);
        for (int i = 0; i < 6; i++) step();
        @(negedge pclk);
        check("dis_out_valid", 64'(out_valid), 64'd0);
        check("dis_word_cnt", 64'(word_cnt), 64'd0);

        // Overflow survives frame end into IDLE; cleared only by a new frame start
        vs_pulse(1'b1);
        out_ready = 1'b0;
        make_frame(48, 0, 1'b1);
        expect_frame(4);
        send_frame(0);
        vs_pulse(1'b0);
        make_frame(8, 8'h77, 1'b0);
        send_frame(0);
        @(negedge pclk);
        check("idle_ovf_word_cnt", 64'(word_cnt), 64'd4);
        check("idle_ovf_drop", 64'(drop_cnt), DROP_EN ? 64'd2 : 64'd0);
        step();
        out_ready = 1'b1;
        drain("idle_ovf_drain");
        check("idle_ovf_sticky", 64'(overflow), 64'd1);
        step();
        vs_pulse(1'b1);
        @(negedge pclk);
        check("restart_ovf_clr", 64'(overflow), 64'd0);
        check("restart_drop_clr", 64'(drop_cnt), 64'd0);
        step();

        // Full FIFO with simultaneous pop and push
        out_ready = 1'b0;
        make_frame(48, 0, 1'b1);
        expect_frame(8);
        for (int i = 0; i < 47; i++) begin
            pixel_valid = 1'b1;
            pixel       = frame_q[i];
            step();
        end
        pixel     = frame_q[47];
        out_ready = 1'b1;
        step();
        pixel_valid = 1'b0;
        vs_pulse(1'b1);
        drain("full_rw_drain");
        check("full_rw_overflow", 64'(overflow), 64'd0);
        check("full_rw_word_cnt", 64'(word_cnt), 64'd6);

        // Zero-byte frame
        vs_pulse(1'b1);
        step();
        @(negedge pclk);
        check("empty_frame_word_cnt", 64'(word_cnt), 64'd0);
        check("empty_frame_valid", 64'(out_valid), 64'd0);
        step();

        // Random frames with random gaps and random backpressure
        rand_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            n = $urandom_range(40);
            make_frame(n, 0, 1'b1);
            expect_frame(8);
            send_frame(50);
            vs_pulse(1'b1);
            @(negedge pclk);
            check("rnd_word_cnt", 64'(word_cnt), 64'((n + 7) / 8));
            check("rnd_overflow", 64'(overflow), 64'd0);
            step();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain("rnd_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
